// File: rtl/guitar_input_conditioner.sv
// Guitar controller front end: 2-flop synchronisers, per-input debounce, and a held
// strum event with fret snapshot that clears on the next game tick.

module guitar_debounce_lane #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_WIDTH       = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o
);
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 s1_q, s2_q, stable_q, stable_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Any return to the stable value restarts the count, so only an unbroken run commits.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (s2_q != stable_q) begin
      if (cnt_q == LAST) stable_d = s2_q;
      else               cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= raw_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
endmodule

module guitar_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_WIDTH       = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] raw_buttons,
  input  logic       raw_strum,
  input  logic       gameclk_in,
  output logic [3:0] buttons,
  output logic       strum,
  output logic       gameclk,
  output logic [7:0] drop_count
);
  localparam int NUM_IN = 5;

  logic [NUM_IN-1:0] raw_in, deb;
  assign raw_in = {raw_strum, raw_buttons};

  for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
    guitar_debounce_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH)
    ) u_lane (
      .clock   (clock),
      .reset   (reset),
      .raw_i   (raw_in[i]),
      .stable_o(deb[i])
    );
  end

  logic       gclk_s1_q, gclk_s2_q, gclk_prev_q, strum_prev_q;
  logic       strum_q, strum_d;
  logic [3:0] snap_q, snap_d;
  logic [7:0] drop_q, drop_d;
  logic       strum_rise, tick_rise;

  assign strum_rise = deb[4] & ~strum_prev_q;
  assign tick_rise  = gclk_s2_q & ~gclk_prev_q;

  // A new press outranks a simultaneous tick so the event is never lost.
  always_comb begin
    strum_d = strum_q;
    snap_d  = snap_q;
    drop_d  = drop_q;
    if (strum_rise) begin
      strum_d = 1'b1;
      snap_d  = deb[3:0];
      if (strum_q && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end else if (tick_rise) begin
      strum_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gclk_s1_q    <= 1'b0;
      gclk_s2_q    <= 1'b0;
      gclk_prev_q  <= 1'b0;
      strum_prev_q <= 1'b0;
      strum_q      <= 1'b0;
      snap_q       <= 4'b0;
      drop_q       <= 8'b0;
    end else begin
      gclk_s1_q    <= gameclk_in;
      gclk_s2_q    <= gclk_s1_q;
      gclk_prev_q  <= gclk_s2_q;
      strum_prev_q <= deb[4];
      strum_q      <= strum_d;
      snap_q       <= snap_d;
      drop_q       <= drop_d;
    end
  end

  assign buttons    = strum_q ? snap_q : deb[3:0];
  assign strum      = strum_q;
  assign gameclk    = gclk_s2_q;
  assign drop_count = drop_q;
endmodule
